// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] npc;
   } fetch_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
   localparam int unsigned FETCH_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory port and decode-side valid/ready port of the fetch queue.
interface fetch_queue_if;

   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_ins;
   logic [31:0] out_npc;

   modport master (
      output imem_req, imem_addr, out_valid, out_ins, out_npc,
      input  imem_rdata, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_ins, out_npc,
      output imem_rdata, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; wrap-around pointers plus occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  din,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  dout,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, credit-based request issue, redirect flush, buffered output to decode.
// FETCH_BYPASS_EN: a response arriving into an empty queue drives the outputs the same cycle.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = FETCH_DEPTH_DEFAULT,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          halt,
   fetch_queue_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]   fpc;
   logic [31:0]   issued_npc;
   logic          inflight;
   logic          kill;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          issue;
   logic          pop;
   logic          resp_ok;
   logic          fifo_push;
   logic          fifo_pop;
   logic [1:0]    unused_pc_lsb;
   fetch_entry_t  resp;
   fetch_entry_t  head;

   assign unused_pc_lsb = redirect_pc[1:0];

   assign resp    = '{ins: bus.imem_rdata, npc: issued_npc};
   assign resp_ok = inflight && !kill && !redirect && !rst;

`ifdef FETCH_BYPASS_EN
   logic bypass;

   assign bypass        = (count == '0) && resp_ok;
   assign bus.out_valid = ((count != '0) && !redirect) || bypass;
   assign bus.out_ins   = bypass ? resp.ins : head.ins;
   assign bus.out_npc   = bypass ? resp.npc : head.npc;
   assign fifo_push     = resp_ok && !(bypass && bus.out_ready);
`else
   assign bus.out_valid = (count != '0) && !redirect;
   assign bus.out_ins   = head.ins;
   assign bus.out_npc   = head.npc;
   assign fifo_push     = resp_ok;
`endif

   assign pop      = bus.out_valid && bus.out_ready;
   assign fifo_pop = (count != '0) && bus.out_ready && !redirect;

   // Credit: entries held next cycle must leave room for the response of a new request.
   assign occ   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue = !rst && !redirect && !halt && (occ < (CW+1)'(DEPTH));

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fpc[9:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc        <= RESET_PC;
         issued_npc <= '0;
         inflight   <= 1'b0;
         kill       <= 1'b0;
      end else begin
         inflight <= issue;
         kill     <= redirect && inflight;
         if (redirect) begin
            fpc <= {redirect_pc[31:2], 2'b00};
         end else if (issue) begin
            fpc        <= fpc + 32'd4;
            issued_npc <= fpc + 32'd4;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (resp),
      .pop   (fifo_pop),
      .flush (redirect),
      .dout  (head),
      .count (count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirect, halt, mid-run reset.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   int          total;
   int          bad;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word i holds 32'h1000_0000 + i, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] npc);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_ins"}, bus.out_ins, ins);
      chk({tag, "_npc"}, bus.out_npc, npc);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b1;
      redirect      = 1'b0;
      redirect_pc   = '0;
      halt          = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      cyc();
      cyc();
      #1;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", 32'(bus.imem_addr), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ins", bus.out_ins, 32'd0);
      chk("rst_npc", bus.out_npc, 32'd0);

      // Streaming from reset with decode always ready
      cyc();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("c0_req", 32'(bus.imem_req), 32'd1);
      chk("c0_addr", 32'(bus.imem_addr), 32'd0);
      chk("c0_valid", 32'(bus.out_valid), 32'd0);
      for (int i = 1; i < LAT; i++) begin
         cyc();
         #1;
         chk("lat_valid", 32'(bus.out_valid), 32'd0);
      end
      for (int k = 0; k < 6; k++) begin
         cyc();
         #1;
         chk_out("stream", 32'h1000_0000 + 32'(k), 32'(4 * (k + 1)));
      end

      // Reset pulse mid-stream, then decode stalled for 10 cycles
      cyc();
      rst = 1'b1;
      #1;
      chk("rst2_req", 32'(bus.imem_req), 32'd0);
      for (int c = 0; c < 10; c++) begin
         cyc();
         rst = 1'b0;
         bus.out_ready = 1'b0;
         #1;
         chk("stall_req", 32'(bus.imem_req), (c <= 3) ? 32'd1 : 32'd0);
         chk("stall_valid", 32'(bus.out_valid), (c >= LAT) ? 32'd1 : 32'd0);
      end
      chk("stall_head", bus.out_npc, 32'd4);
      for (int k = 0; k < 6; k++) begin
         cyc();
         bus.out_ready = 1'b1;
         #1;
         if (k == 0) begin
            chk("drain_req", 32'(bus.imem_req), 32'd1);
            chk("drain_addr", 32'(bus.imem_addr), 32'd4);
         end
         chk_out("drain", 32'h1000_0000 + 32'(k), 32'(4 * (k + 1)));
      end

      // Redirect with three entries buffered and one in flight
      cyc();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      #1;
      chk("redir_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_req", 32'(bus.imem_req), 32'd0);
      cyc();
      redirect = 1'b0;
      #1;
      chk("redir1_req", 32'(bus.imem_req), 32'd1);
      chk("redir1_addr", 32'(bus.imem_addr), 32'h10);
      chk("redir1_valid", 32'(bus.out_valid), 32'd0);
      for (int i = 1; i < LAT; i++) begin
         cyc();
         #1;
         chk("redir_lat_valid", 32'(bus.out_valid), 32'd0);
      end
      cyc();
      #1;
      chk_out("redir_first", 32'h1000_0010, 32'h44);
      cyc();
      #1;
      chk_out("redir_second", 32'h1000_0011, 32'h48);

      // Redirect to an unaligned PC, then halt for 5 cycles with a request in flight
      cyc();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0043;
      #1;
      chk("unal_valid", 32'(bus.out_valid), 32'd0);
      cyc();
      redirect = 1'b0;
      #1;
      chk("unal_req", 32'(bus.imem_req), 32'd1);
      chk("unal_addr", 32'(bus.imem_addr), 32'h10);
      chk("unal_valid1", 32'(bus.out_valid), 32'd0);
      for (int h = 0; h < 5; h++) begin
         cyc();
         halt = 1'b1;
         #1;
         chk("halt_req", 32'(bus.imem_req), 32'd0);
         if (h == LAT - 1) chk_out("halt_drain", 32'h1000_0010, 32'h44);
         else chk("halt_valid", 32'(bus.out_valid), 32'd0);
      end
      cyc();
      halt = 1'b0;
      #1;
      chk("resume_req", 32'(bus.imem_req), 32'd1);
      chk("resume_addr", 32'(bus.imem_addr), 32'h11);
      for (int i = 1; i < LAT; i++) begin
         cyc();
         #1;
         chk("resume_lat_valid", 32'(bus.out_valid), 32'd0);
      end
      cyc();
      #1;
      chk_out("resume", 32'h1000_0011, 32'h48);

      // Fill the queue, then reset while full
      for (int c = 0; c < 8; c++) begin
         cyc();
         bus.out_ready = 1'b0;
      end
      #1;
      chk("full_valid", 32'(bus.out_valid), 32'd1);
      chk("full_req", 32'(bus.imem_req), 32'd0);
      cyc();
      rst = 1'b1;
      #1;
      chk("rst3_req", 32'(bus.imem_req), 32'd0);
      cyc();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst3_valid", 32'(bus.out_valid), 32'd0);
      chk("rst3_req0", 32'(bus.imem_req), 32'd1);
      chk("rst3_addr", 32'(bus.imem_addr), 32'd0);
      for (int i = 1; i < LAT; i++) begin
         cyc();
         #1;
         chk("rst3_lat_valid", 32'(bus.out_valid), 32'd0);
      end
      cyc();
      #1;
      chk_out("rst3_first", 32'h1000_0000, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues word requests to the synchronous instruction memory, buffers returned instructions with their PC+4 in a small FIFO, and presents them to the decode stage over a valid/ready handshake. Handles taken-branch/jump/trap redirects from the MEM stage by flushing all buffered and in-flight fetches.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `redirect` input 1: pulse; discard all fetches, restart at `redirect_pc`.
- `redirect_pc` input 32: new fetch PC; bits [1:0] ignored (treated as 0).
- `halt` input 1: breakpoint; no new requests issued while high.
- `imem_req` output 1: request valid this cycle.
- `imem_addr` output 8: word address = fetch PC[9:2].
- `imem_rdata` input 32: instruction, valid the cycle after `imem_req`.
- `out_valid` output 1: `out_ins`/`out_npc` hold a valid instruction.
- `out_ready` input 1: consumer accepts (low = decode stall).
- `out_ins` output 32: instruction word.
- `out_npc` output 32: that instruction's PC + 4.

## Operation
- State: fetch PC `fpc`, in-flight flag `inflight`, flush tag `kill`, FIFO of {ins, npc}, occupancy `count` (0..DEPTH).
- Issue rule: `imem_req = !rst && !redirect && !halt && (count + inflight − pop) < DEPTH`, pop = `out_valid && out_ready`. On issue: `fpc <= fpc + 4`, `inflight <= 1`, record issued PC + 4 as npc of that slot.
- Response: cycle after issue, if `kill` clear, push {imem_rdata, npc} into FIFO.
- Pop: head leaves on `out_valid && out_ready`. Push and pop in same cycle allowed at any occupancy, including full.
- Redirect: `fpc <= {redirect_pc[31:2],2'b00}`, `count <= 0`, `kill <= inflight` (drops the response arriving next cycle), no request that cycle; `out_valid` forced 0 in the redirect cycle. Request at the new PC issued the following cycle.
- Redirect has priority over halt, pop and push in the same cycle.
- Halt: in-flight fetch still completes and is pushed; FIFO continues draining; `fpc` holds.
- Wrap: `fpc` wraps modulo 2^32; `imem_addr` wraps modulo 256 words.
- Credit rule guarantees no overflow; pop on empty never occurs (`out_valid` = `count != 0`).

## Timing
- Reset values: `fpc = RESET_PC`, `count = 0`, `inflight = 0`, `kill = 0`; `imem_req = 0`, `imem_addr = RESET_PC[9:2]`, `out_valid = 0`, `out_ins = 0`, `out_npc = 0`.
- Cycle 0 = first cycle with `rst` low: request RESET_PC. Cycle 1: data pushed. Cycle 2: `out_valid = 1` (2-cycle fetch latency without bypass).
- Steady state with `out_ready` high: one instruction per cycle for any DEPTH ≥ 2.
- Redirect at cycle R: request new PC at R+1, output at R+3 (R+2 with bypass).
- `rst` asserted mid-operation: all state returns to reset values at the next edge; in-flight data discarded.

## Configuration
- `FETCH_BYPASS_EN` defined: when FIFO empty and a non-killed response arrives, it drives `out_ins`/`out_npc`/`out_valid` combinationally that cycle; if `out_ready` high it is consumed without being pushed, else pushed. Latency 1 cycle; redirect cycle still forces `out_valid = 0`.
- Undefined: all responses go through the FIFO; latency 2 cycles; outputs purely registered.

## Structure
- Shared package `fetch_pkg`: `fetch_entry_t` {ins[31:0], npc[31:0]}, `RESET_PC_DEFAULT`, `FETCH_DEPTH_DEFAULT`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH entries, push/pop/flush, `count` output; wrap-around read/write pointers of log2(DEPTH) bits plus count.
- Top handles PC, credit, kill and redirect logic.

## Test plan
- Reset release, imem word i = 32'h1000_0000+i, `out_ready` high -> `out_valid` from cycle 2, outputs (ins,npc) = (32'h1000_0000,4), (32'h1000_0001,8), ... one per cycle.
- `out_ready` low for 10 cycles -> exactly DEPTH=4 entries buffered, `imem_req` low once full; raising `out_ready` yields npc 4,8,12,16,20 consecutive, no loss or duplicate.
- `redirect` with `redirect_pc` = 32'h0000_0040 while 3 entries buffered and one in flight -> `out_valid` 0 for redirect cycle, next delivered npc = 32'h44, no stale instruction appears.
- `redirect_pc` = 32'h0000_0043 -> fetch address word 16 (`imem_addr` = 8'h10), `out_npc` = 32'h44.
- `halt` high for 5 cycles with in-flight request -> that instruction still delivered, `imem_req` 0 throughout, fetch resumes at next sequential PC after halt drops.
- `rst` pulsed while FIFO full -> `out_valid` 0 next cycle, refetch from RESET_PC; with `FETCH_BYPASS_EN`, first `out_valid` at cycle 1.
